// File: rtl/chipper_pkg.sv
// Shared CHIPPER router types: flit layout, field ranges and flit helpers.
package chipper_pkg;

   localparam int FLIT_W  = 10;
   localparam int VLD_BIT = 9;
   localparam int BODY_W  = FLIT_W - 1;

   // Body field ranges (valid bit sits above the body)
   localparam int DX_HI  = 8;
   localparam int DX_LO  = 7;
   localparam int DY_HI  = 6;
   localparam int DY_LO  = 5;
   localparam int PAY_HI = 4;
   localparam int PAY_LO = 0;

   typedef logic [FLIT_W-1:0] flit_t;
   typedef logic [BODY_W-1:0] body_t;

   function automatic flit_t mk_flit(input body_t b);
      return {1'b1, b};
   endfunction

endpackage

// File: rtl/inject_queue_if.sv
// Node-side request handshake into the injection queue.
interface inject_queue_if;
   import chipper_pkg::*;

   logic  miss_valid;
   body_t miss_flit;
   logic  miss_ready;

   modport master (output miss_valid, output miss_flit, input miss_ready);
   modport slave  (input miss_valid, input miss_flit, output miss_ready);
endinterface

// File: rtl/inject_queue_fifo.sv
// Registered-head FIFO: writes land at the tail, no fall-through to head.
module flit_fifo #(
   parameter int DEPTH = 4,
   parameter int W     = 9,
   localparam int PTR_W = $clog2(DEPTH),
   localparam int OCC_W = $clog2(DEPTH) + 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             push,
   input  logic             pop,
   input  logic [W-1:0]     din,
   output logic [W-1:0]     head,
   output logic [OCC_W-1:0] occupancy,
   output logic             full,
   output logic             empty
);

   logic [W-1:0]     mem [DEPTH];
   logic [PTR_W-1:0] wptr, rptr;

   assign full  = (occupancy == OCC_W'(DEPTH));
   assign empty = (occupancy == '0);
   assign head  = mem[rptr];

   always_ff @(posedge clk) begin
      if (push) mem[wptr] <= din;
   end

   // Pointers wrap naturally since DEPTH is a power of two
   always_ff @(posedge clk) begin
      if (rst) begin
         wptr      <= '0;
         rptr      <= '0;
         occupancy <= '0;
      end else begin
         if (push) wptr <= wptr + 1'b1;
         if (pop)  rptr <= rptr + 1'b1;
         if (push && !pop)      occupancy <= occupancy + 1'b1;
         else if (pop && !push) occupancy <= occupancy - 1'b1;
      end
   end

endmodule

// File: rtl/inject_queue.sv
// Local injection buffer: queues node flits and injects one onto the local
// lane whenever any of the four link lanes is empty; flags long starvation.
module inject_queue
   import chipper_pkg::*;
#(
   parameter int DEPTH        = 4,
   parameter int STARVE_LIMIT = 15,
   localparam int OCC_W = $clog2(DEPTH) + 1,
   localparam int CNT_W = $clog2(STARVE_LIMIT + 1)
) (
   input  logic                 clk,
   input  logic                 rst,
   inject_queue_if.slave        miss,
   input  logic                 nvld,
   input  logic                 ssig_vld,
   input  logic                 evld,
   input  logic                 wvld,
   output flit_t                lin,
   output logic [OCC_W-1:0]     occupancy,
   output logic                 starve
);

   logic             full, empty, push, free, inject;
   body_t            head;
   logic [CNT_W-1:0] starve_cnt;

   // Full blocks acceptance even when a pop happens this cycle
   assign miss.miss_ready = !full && !rst;
   assign push            = miss.miss_valid && miss.miss_ready;
   assign free            = !(nvld && ssig_vld && evld && wvld);
   assign inject          = free && !empty;
   assign lin             = inject ? mk_flit(head) : '0;

   flit_fifo #(.DEPTH(DEPTH), .W(BODY_W)) u_fifo (
      .clk       (clk),
      .rst       (rst),
      .push      (push),
      .pop       (inject),
      .din       (miss.miss_flit),
      .head      (head),
      .occupancy (occupancy),
      .full      (full),
      .empty     (empty)
   );

   always_ff @(posedge clk) begin
      if (rst || inject || empty)
         starve_cnt <= '0;
      else if (starve_cnt != CNT_W'(STARVE_LIMIT))
         starve_cnt <= starve_cnt + 1'b1;
   end

   assign starve = (starve_cnt == CNT_W'(STARVE_LIMIT));

endmodule
